// File: rtl/xorshift_sequencer_pkg.sv
// Shared definitions for the xorshift sequencer.
//   XS_DEFAULT_SEED : generator state after reset, and the stand-in for a zero
//                     seed (zero is the fixed point of xorshift).
//   word_t          : 32-bit generator word.
//   state_e         : FSM state names, for debug decode.
//   ST_IDLE/ST_RUN  : FSM state encodings used by the RTL.
package xorshift_sequencer_pkg;

  typedef logic [31:0] word_t;

  localparam word_t XS_DEFAULT_SEED = 32'h2545F491;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/xorshift_sequencer_if.sv
// Bundle of the sequencer's control, seed and output-stream signals.
//   seed_valid/seed_data/seed_ready : seed load handshake
//   start/req_count/stop            : burst control
//   busy/done                       : burst status
//   rnd_valid/rnd_data/rnd_ready/rnd_last : output word stream
// Handshake rule for both seed and rnd channels: a transfer happens on a
// rising clock edge where valid and ready are both high; the source holds
// data stable while valid is high and ready is low.
// Modports: slave = the sequencer, master = the controller/consumer side.
interface xorshift_sequencer_if
  import xorshift_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             seed_valid;
  word_t            seed_data;
  logic             seed_ready;
  logic             start;
  logic [CNT_W-1:0] req_count;
  logic             stop;
  logic             busy;
  logic             done;
  logic             rnd_valid;
  word_t            rnd_data;
  logic             rnd_ready;
  logic             rnd_last;

  modport slave (
    input  seed_valid, seed_data, start, req_count, stop, rnd_ready,
    output seed_ready, busy, done, rnd_valid, rnd_data, rnd_last
  );

  modport master (
    output seed_valid, seed_data, start, req_count, stop, rnd_ready,
    input  seed_ready, busy, done, rnd_valid, rnd_data, rnd_last
  );
endinterface

// File: rtl/xorshift_sequencer_xorshifter.sv
// Combinational xorshift step (shifts 7/9/13).
//   x_in  : current generator word
//   x_out : next generator word
module xorshift_sequencer_xorshifter
  import xorshift_sequencer_pkg::*;
(
  input  word_t x_in,
  output word_t x_out
);
  word_t s1;
  word_t s2;

  assign s1    = x_in ^ (x_in >> 7);
  assign s2    = s1 ^ (s1 << 9);
  assign x_out = s2 ^ (s2 >> 13);
endmodule

// File: rtl/xorshift_sequencer.sv
// Sequential xorshift generator: holds the state register, loads seeds,
// runs counted (req_count>0) or free-running (req_count==0) bursts and
// streams each word over the rnd valid/ready channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : control/seed/stream bundle (slave side)
//   state_dbg  : current FSM state
module xorshift_sequencer
  import xorshift_sequencer_pkg::*;
#(
  parameter word_t DEFAULT_SEED = XS_DEFAULT_SEED,
  parameter int    CNT_W        = 16
)(
  input  logic                  clk,
  input  logic                  rst_n,
  xorshift_sequencer_if.slave   bus,
  output state_e                state_dbg
);
  logic [0:0]       state;
  word_t            sreg;
  logic [CNT_W-1:0] remaining;
  logic             rnd_valid_q;
  logic             done_q;

  word_t seed_load;
  word_t seed_eff;
  word_t xs_in;
  word_t xs_out;
  logic  hs;

  // A zero seed would lock the generator at zero forever.
  assign seed_load = (bus.seed_data == '0) ? DEFAULT_SEED : bus.seed_data;
  // A seed offered together with start is used for that burst's first word.
  assign seed_eff  = bus.seed_valid ? seed_load : sreg;
  assign xs_in     = (state == ST_IDLE) ? seed_eff : sreg;
  assign hs        = rnd_valid_q && bus.rnd_ready;

  xorshift_sequencer_xorshifter u_xs (
    .x_in  (xs_in),
    .x_out (xs_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sreg        <= DEFAULT_SEED;
      remaining   <= '0;
      rnd_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            sreg        <= xs_out;
            rnd_valid_q <= 1'b1;
            remaining   <= bus.req_count;
            state       <= ST_RUN;
          end else if (bus.seed_valid) begin
            sreg <= seed_load;
          end
        end
        ST_RUN: begin
          // sreg is left holding the word on rnd_data so a later start
          // continues the same sequence.
          if (bus.stop || (hs && remaining == CNT_W'(1))) begin
            rnd_valid_q <= 1'b0;
            remaining   <= '0;
            done_q      <= 1'b1;
            state       <= ST_IDLE;
          end else if (hs) begin
            sreg <= xs_out;
            // remaining==0 marks free-run and never counts.
            if (remaining != '0) remaining <= remaining - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.seed_ready = (state == ST_IDLE);
  assign bus.busy       = (state == ST_RUN);
  assign bus.done       = done_q;
  assign bus.rnd_valid  = rnd_valid_q;
  assign bus.rnd_data   = sreg;
  assign bus.rnd_last   = rnd_valid_q && (remaining == CNT_W'(1));
  assign state_dbg      = state_e'(state);
endmodule

// File: tb/tb_xorshift_sequencer.sv
module tb_xorshift_sequencer;
  import xorshift_sequencer_pkg::*;

  localparam int    CNT_W    = 16;
  localparam word_t DEF_SEED = 32'h2545F491;

  logic   clk;
  logic   rst_n;
  state_e state_dbg;

  xorshift_sequencer_if #(.CNT_W(CNT_W)) bus ();

  xorshift_sequencer #(.DEFAULT_SEED(DEF_SEED), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    n_checks = 0;
  int    n_pass   = 0;
  word_t m_sreg;
  logic [31:0] exp_q[$];

  // golden xorshift step written from the rule x^=x>>7; x^=x<<9; x^=x>>13
  function automatic word_t xs_step(input word_t v);
    word_t t;
    t = v;
    t = t ^ (t >> 7);
    t = t ^ (t << 9);
    t = t ^ (t >> 13);
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one burst and scoreboard its output. cnt==0 means free-run: nwords
  // are consumed and then the burst is stopped with the next word pending.
  task automatic burst(input bit load, input word_t seed, input int cnt, input int nwords,
                       input int ready_pct, input int stall_first, input bit noise);
    word_t x;
    int target;
    int got;
    int cyc;
    x = load ? ((seed == '0) ? DEF_SEED : seed) : m_sreg;
    target = (cnt != 0) ? cnt : nwords;
    exp_q.delete();
    for (int i = 0; i < target + ((cnt == 0) ? 1 : 0); i++) begin
      x = xs_step(x);
      exp_q.push_back(x);
    end
    bus.seed_valid = load;
    bus.seed_data  = seed;
    bus.req_count  = cnt[CNT_W-1:0];
    bus.start      = 1'b1;
    cycle();
    bus.seed_valid = 1'b0;
    bus.start      = 1'b0;
    got = 0;
    cyc = 0;
    while (got < target && cyc < 5000) begin
      bus.rnd_ready = (cyc >= stall_first) && ($urandom_range(99) < ready_pct);
      if (noise) begin
        bus.seed_valid = 1'($urandom_range(1));
        bus.seed_data  = $urandom;
        bus.start      = 1'($urandom_range(1));
      end
      check("valid", {31'd0, bus.rnd_valid}, 32'd1);
      check("data", bus.rnd_data, exp_q[0]);
      check("last", {31'd0, bus.rnd_last}, {31'd0, (cnt != 0 && exp_q.size() == 1)});
      check("busy", {31'd0, bus.busy}, 32'd1);
      check("seed_ready_run", {31'd0, bus.seed_ready}, 32'd0);
      if (bus.rnd_ready && bus.rnd_valid) begin
        m_sreg = exp_q.pop_front();
        got++;
      end
      cycle();
      cyc++;
    end
    if (got < target) check("timeout", got, target);
    bus.rnd_ready  = 1'b0;
    bus.seed_valid = 1'b0;
    bus.start      = 1'b0;
    if (cnt != 0) begin
      check("done_end", {31'd0, bus.done}, 32'd1);
    end else begin
      check("data_pending", bus.rnd_data, exp_q[0]);
      bus.stop = 1'b1;
      m_sreg = exp_q[0];
      cycle();
      bus.stop = 1'b0;
      check("done_stop", {31'd0, bus.done}, 32'd1);
    end
    check("valid_end", {31'd0, bus.rnd_valid}, 32'd0);
    check("busy_end", {31'd0, bus.busy}, 32'd0);
    check("seed_ready_idle", {31'd0, bus.seed_ready}, 32'd1);
    cycle();
    check("done_pulse", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.seed_valid = 1'b0;
    bus.seed_data  = '0;
    bus.start      = 1'b0;
    bus.req_count  = '0;
    bus.stop       = 1'b0;
    bus.rnd_ready  = 1'b0;
    m_sreg         = DEF_SEED;
    #12;
    check("rst_valid", {31'd0, bus.rnd_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_last", {31'd0, bus.rnd_last}, 32'd0);
    check("rst_data", bus.rnd_data, DEF_SEED);
    check("rst_seed_ready", {31'd0, bus.seed_ready}, 32'd1);
    cycle();
    rst_n = 1'b1;
    cycle();

    // directed: seed 1, count 2, ready high
    bus.seed_valid = 1'b1;
    bus.seed_data  = 32'h1;
    cycle();
    bus.seed_valid = 1'b0;
    bus.start      = 1'b1;
    bus.req_count  = 16'd2;
    bus.rnd_ready  = 1'b1;
    cycle();
    bus.start = 1'b0;
    check("dir_w0", bus.rnd_data, 32'h00000201);
    check("dir_last0", {31'd0, bus.rnd_last}, 32'd0);
    cycle();
    check("dir_w1", bus.rnd_data, 32'h00040825);
    check("dir_last1", {31'd0, bus.rnd_last}, 32'd1);
    check("dir_done_early", {31'd0, bus.done}, 32'd0);
    cycle();
    bus.rnd_ready = 1'b0;
    check("dir_done", {31'd0, bus.done}, 32'd1);
    check("dir_busy", {31'd0, bus.busy}, 32'd0);
    cycle();
    check("dir_done_clr", {31'd0, bus.done}, 32'd0);
    m_sreg = 32'h00040825;

    // same burst with a 5-cycle stall, then seed+start together
    burst(1'b1, 32'h1, 2, 0, 100, 5, 1'b0);
    burst(1'b1, 32'h1, 1, 0, 100, 0, 1'b0);
    // zero seed maps to the default seed
    burst(1'b1, 32'h0, 1, 0, 100, 0, 1'b0);
    // free-run from seed 1, then stop with a word pending, then continue
    burst(1'b1, 32'h1, 0, 1000, 70, 0, 1'b1);
    burst(1'b0, 32'h0, 3, 0, 60, 0, 1'b0);
    // randomized bursts with seed/start noise during RUN
    for (int k = 0; k < 8; k++) begin
      burst(1'($urandom_range(1)), ($urandom_range(3) == 0) ? 32'h0 : $urandom,
            ($urandom_range(4) == 0) ? 0 : int'($urandom_range(8, 1)),
            int'($urandom_range(20, 1)), int'($urandom_range(100, 40)), 0, 1'b1);
    end

    // asynchronous reset mid-burst
    bus.seed_valid = 1'b1;
    bus.seed_data  = $urandom;
    bus.start      = 1'b1;
    bus.req_count  = 16'd10;
    bus.rnd_ready  = 1'b1;
    cycle();
    bus.seed_valid = 1'b0;
    bus.start      = 1'b0;
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.rnd_valid}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_last", {31'd0, bus.rnd_last}, 32'd0);
    check("arst_data", bus.rnd_data, DEF_SEED);
    bus.rnd_ready = 1'b0;
    cycle();
    rst_n = 1'b1;
    m_sreg = DEF_SEED;
    cycle();
    burst(1'b0, 32'h0, 1, 0, 100, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/xorshift_sequencer.md
Name: xorshift_sequencer

Overview:
Sequential wrapper around the team's combinational XORShifter step function (32-bit xorshift with shifts 7/9/13).
- Holds the generator state in a register.
- Accepts seeds and runs counted or free-running bursts.
- Streams each new 32-bit word downstream over a valid/ready handshake.
- Sits between the control/seed source and any random-number consumer.

Parameters:
DEFAULT_SEED, 32'h2545F491, state after reset; also substitutes for a zero seed (0 is the xorshift fixed point)
CNT_W, 16, width of the burst-length counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
seed_valid  in  1  seed offered
seed_data  in  32  seed value
seed_ready  out  1  seed accepted this cycle if seed_valid is also high; equals (state==IDLE)
start  in  1  begin a burst (honoured only in IDLE)
req_count  in  CNT_W  burst length, sampled with start; 0 = free-run
stop  in  1  abort burst
busy  out  1  high in RUN
done  out  1  one-cycle pulse after the last word of a counted burst is accepted, or after an abort
rnd_valid  out  1  word available
rnd_data  out  32  generated word
rnd_ready  in  1  consumer accepts
rnd_last  out  1  high with the final word of a counted burst

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sreg=DEFAULT_SEED, remaining=0, rnd_valid=0, rnd_last=0, done=0, busy=0. Reset asserted mid-burst discards everything immediately.
- rnd_data is driven directly from sreg (registered). XS(x) = XORShifter(x).
- FSM IDLE:
  - seed_valid=1: sreg <= (seed_data==0 ? DEFAULT_SEED : seed_data).
  - start=1: sreg <= XS(seed_eff), rnd_valid<=1, remaining<=req_count, go RUN.
  - seed_eff = the newly loaded seed if seed_valid is high in the same cycle (seed has priority and is used), else the current sreg.
  - First word is valid the cycle after start is sampled (latency 1).
- FSM RUN:
  - Handshake when rnd_valid && rnd_ready.
  - On handshake with remaining==1: rnd_valid<=0, rnd_last<=0, done<=1, go IDLE. sreg keeps the last emitted word, so the next start continues the same sequence.
  - On handshake otherwise: sreg <= XS(sreg). remaining decrements, except in free-run (remaining==0), where it never changes.
  - rnd_last = (remaining==1) while rnd_valid.
  - Without a handshake, rnd_data and rnd_last hold stable.
- Abort: stop=1 in RUN leads to IDLE next cycle with rnd_valid=0 and done=1.
  - If a handshake occurs in the same cycle, that word counts as delivered; otherwise the pending word is dropped.
  - In both cases sreg keeps the current word.
- stop in IDLE is ignored. start and seed_valid in RUN are ignored (seed_ready=0).
- Counter arithmetic is unsigned CNT_W; maximum burst is 2^CNT_W-1.
- done is never asserted together with rnd_valid in the same cycle.

Decomposition:
- Shared package: DEFAULT_SEED constant; the state enum {IDLE, RUN}; a 32-bit word typedef.
- One sub-module instance: XORShifter (combinational next-state), fed by a mux between sreg and seed_eff.
- FSM, counter and handshake logic stay in xorshift_sequencer.

Test Plan:
- Seed 32'h00000001, start with req_count=2, rnd_ready=1 → words 32'h00000201, then 32'h00040825 (rnd_last=1); done pulses 1 cycle after the second word; busy back to 0.
- Same burst with rnd_ready held 0 for 5 cycles → rnd_data=32'h00000201 and rnd_valid held stable; no advance until ready; total words =2.
- Seed 0 then start, req_count=1 → first word = XS(DEFAULT_SEED) per the golden model; never all zeros.
- Free-run (req_count=0) from seed 1: 1000 words match the golden xorshift model; rnd_last stays 0. stop with rnd_ready=0 → word dropped, done=1, rnd_valid=0 the next cycle; a following start continues from the held sreg.
- seed_valid and start in the same IDLE cycle, seed=1 → first word 32'h00000201. seed_valid during RUN → seed_ready=0, sequence unaffected.
- rst_n pulsed low mid-burst (asynchronously, between clock edges) → outputs zero immediately; after release, start with count 1 → XS(DEFAULT_SEED).
